lane_hazard_ctrl: RTL and testbench
===================================

// Module: lane_hazard_ctrl
// PURPOSE
// - Parametrised hazard engine for the Frogger playfield; replaces the single-car car_ctrl with N lanes of moving objects.
// - Each lane is a road lane (cars kill) or a water lane (logs carry; no log drowns). Each lane has its own direction and step rate.
// - Feeds the pixel renderer with per-tile occupancy, and feeds frogger_ctrl with hit, drown and carry events.
// PARAMETERS
// - c_NUM_LANES     4         number of hazard lanes (1..8)
// - c_FIRST_ROW     7         tile row of lane 0; lane n sits on row c_FIRST_ROW+n
// - c_GAME_WIDTH    14        playfield columns; X wraps modulo this value
// - c_OBJ_PER_LANE  2         objects per lane; spacing S = c_GAME_WIDTH/c_OBJ_PER_LANE
// - c_OBJ_LEN       2         object length in tiles (1..S)
// - c_BASE_PERIOD   20000000  i_Clk cycles per base tick
// - c_LANE_DIV      32'h0     4 bits per lane; lane n steps every (DIV[n]+1) base ticks
// - c_LANE_DIR      8'h0      bit n: 1 = lane n moves right (+X), 0 = left
// - c_LANE_WATER    8'h0      bit n: 1 = water/log lane, 0 = road/car lane
// PORTS
// - i_Clk            in   1  system clock
// - i_Rst            in   1  asynchronous reset, active-high
// - i_Enable         in   1  1 = lanes move; 0 = freeze all counters and offsets
// - i_Restart        in   1  synchronous re-seed pulse (new game / life lost)
// - i_Col_Count_Div  in   5  render tile column
// - i_Row_Count_Div  in   5  render tile row
// - i_Frogger_X      in   6  frog tile column
// - i_Frogger_Y      in   6  frog tile row
// - o_Tile_Obj       out  1  render tile holds an object (combinational)
// - o_Tile_Water     out  1  render tile is in a water lane (combinational)
// - o_Collided       out  1  frog on a car tile (registered)
// - o_Drowned        out  1  frog in a water lane off a log, or carried past an edge (registered)
// - o_Carry_Pulse    out  1  1-cycle pulse: the frog's log stepped, move the frog one tile
// - o_Carry_Dir      out  1  direction of that carry (1 = right); valid with o_Carry_Pulse
// BEHAVIOUR
// - Reset: all counters 0; offset[n] = 0; every registered output 0.
// - Base counter:
//   - Counts 0..c_BASE_PERIOD-1 while i_Enable is high; holds while it is low.
//   - Emits an internal tick on the cycle it is at its terminal value, then wraps to 0.
// - Lane divider n counts ticks 0..DIV[n]. On a tick at DIV[n] it wraps to 0 and asserts step[n] for that cycle.
// - Offset on step[n]:
//   - Right: offset+1, with c_GAME_WIDTH-1 -> 0.
//   - Left: offset-1, with 0 -> c_GAME_WIDTH-1.
//   - Offset is always in 0..c_GAME_WIDTH-1.
// - Occupancy of tile (x, lane n):
//   - rel = (x - offset[n]) mod c_GAME_WIDTH, using the subtract_modulo rule.
//   - The tile is occupied iff rel < c_OBJ_PER_LANE*S and (rel mod S) < c_OBJ_LEN.
// - Render query:
//   - Row outside [c_FIRST_ROW, c_FIRST_ROW+c_NUM_LANES-1] or col >= c_GAME_WIDTH -> both tile outputs 0.
// - Frog outputs: registered, 1-cycle latency from i_Frogger_X/Y, evaluated against the current-cycle offsets.
//   - Road lane: o_Collided = occ.
//   - Water lane: o_Drowned = !occ.
//   - Frog outside the lane rows, or X >= c_GAME_WIDTH: all frog outputs 0.
// - Carry: the frog is in water lane n, occ=1, and step[n] is high.
//   - Normal case: o_Carry_Pulse=1 next cycle, with o_Carry_Dir = DIR[n].
//   - Edge case: frog at X=c_GAME_WIDTH-1 moving right, or X=0 moving left. No carry pulse; o_Drowned=1 instead. There is no wrap for the frog.
// - Simultaneous step and query: the hazard decision uses the pre-step offset. The post-step result appears one cycle later.
// - i_Restart:
//   - Has priority over stepping and over i_Enable.
//   - Clears all counters, sets offsets to 0, and clears the registered outputs on the next edge.
// - i_Rst mid-operation clears state immediately. Outputs are 0 until the first post-reset evaluation.
// STRUCTURE
// - frogger_defs.vh holds c_GAME_WIDTH, TILE_SIZE, the tile-type codes (0 wall, 1 road, 2 water, 3 safe, 4 lily) and function subtract_modulo. Shared with frogger_game and frogger_ctrl.
// - Sub-module lane_mover: one instance per lane via generate. Contains the divider, the offset register and step[n], and computes occupancy for two query X values (render and frog).
// - Top level: base tick counter, row-to-lane decode, output muxing and registers.
// TESTING
// - Tick rate: c_BASE_PERIOD=4, DIV[0]=1. Expect a tick every 4 cycles, step[0] every 8 cycles, and offset[0] 0->1->2 after 16 cycles.
// - Wrap: left lane, W=14. After the first step, offset goes 0->13; the rendered object that was at cols 0,1 now shows at cols 13,0.
// - Road hit: OBJ=2, LEN=2, S=7, offset 0. Frog at (1, lane 0 row) gives o_Collided=1; frog at (2, same row) gives 0; frog at (7, same row) gives 1.
// - Log carry: water lane moving right, frog at X=3 on a log. A step produces a 1-cycle o_Carry_Pulse with o_Carry_Dir=1. Move the frog to X=13 on a log: the next step gives o_Drowned=1 and no pulse.
// - Freeze/restart: i_Enable=0 for 100 cycles leaves offsets unchanged. Pulse i_Restart during a step cycle: offsets become 0 and the step is discarded.
// - Async reset mid-run: assert i_Rst between clock edges. Outputs and offsets go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/lane_hazard_ctrl_pkg.sv
// Shared playfield definitions for the lane hazard engine: tile codes, coordinate
// width and wrap-around subtraction used by the lane occupancy logic.
package lane_hazard_ctrl_pkg;

    localparam int unsigned c_X_W = 6;

    typedef enum logic [2:0] {
        TILE_WALL  = 3'd0,
        TILE_ROAD  = 3'd1,
        TILE_WATER = 3'd2,
        TILE_SAFE  = 3'd3,
        TILE_LILY  = 3'd4
    } tile_t;

    // (A - B) mod W for A, B already in 0..W-1
    function automatic logic [c_X_W-1:0] subtract_modulo(
        input logic [c_X_W-1:0] i_A,
        input logic [c_X_W-1:0] i_B,
        input logic [c_X_W-1:0] i_W
    );
        if (i_A >= i_B)
            return i_A - i_B;
        else
            return i_A + i_W - i_B;
    endfunction

endpackage

// File: rtl/lane_hazard_ctrl_mover.sv
// One hazard lane: tick divider, wrapping offset register and occupancy lookup
// for the render column and the frog column.
module lane_mover
    import lane_hazard_ctrl_pkg::*;
#(
    parameter int unsigned c_GAME_WIDTH   = 14,
    parameter int unsigned c_OBJ_PER_LANE = 2,
    parameter int unsigned c_OBJ_LEN      = 2,
    parameter logic [3:0]  c_DIV          = 4'h0,
    parameter logic        c_DIR          = 1'b0
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Restart,
    input  logic             i_Tick,
    input  logic [c_X_W-1:0] i_Render_X,
    input  logic [c_X_W-1:0] i_Frog_X,
    output logic             o_Step,
    output logic             o_Render_Occ,
    output logic             o_Frog_Occ
);

    localparam int unsigned      c_SPACING = c_GAME_WIDTH / c_OBJ_PER_LANE;
    localparam logic [c_X_W-1:0] c_W       = c_X_W'(c_GAME_WIDTH);
    localparam logic [c_X_W-1:0] c_SPAN    = c_X_W'(c_OBJ_PER_LANE * c_SPACING);
    localparam logic [c_X_W-1:0] c_S       = c_X_W'(c_SPACING);
    localparam logic [c_X_W-1:0] c_LEN     = c_X_W'(c_OBJ_LEN);

    logic [3:0]       r_Div;
    logic [c_X_W-1:0] r_Offset;
    logic             w_Step;

    function automatic logic f_occupied(
        input logic [c_X_W-1:0] i_X,
        input logic [c_X_W-1:0] i_Off
    );
        logic [c_X_W-1:0] v_Rel;
        v_Rel = subtract_modulo(i_X, i_Off, c_W);
        return (v_Rel < c_SPAN) && ((v_Rel % c_S) < c_LEN);
    endfunction

    assign w_Step = i_Tick && (r_Div == c_DIV);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Div    <= '0;
            r_Offset <= '0;
        end else if (i_Restart) begin
            r_Div    <= '0;
            r_Offset <= '0;
        end else if (i_Tick) begin
            r_Div <= w_Step ? '0 : r_Div + 1'b1;
            if (w_Step) begin
                if (c_DIR)
                    r_Offset <= (r_Offset == c_W - 1'b1) ? '0 : r_Offset + 1'b1;
                else
                    r_Offset <= (r_Offset == '0) ? c_W - 1'b1 : r_Offset - 1'b1;
            end
        end
    end

    assign o_Step       = w_Step;
    assign o_Render_Occ = f_occupied(i_Render_X, r_Offset);
    assign o_Frog_Occ   = f_occupied(i_Frog_X, r_Offset);

endmodule

// File: rtl/lane_hazard_ctrl.sv
// Frogger hazard engine: base tick, N lane movers, render tile lookup and the
// registered hit / drown / carry events for the frog controller.
module lane_hazard_ctrl
    import lane_hazard_ctrl_pkg::*;
#(
    parameter int unsigned c_NUM_LANES    = 4,
    parameter int unsigned c_FIRST_ROW    = 7,
    parameter int unsigned c_GAME_WIDTH   = 14,
    parameter int unsigned c_OBJ_PER_LANE = 2,
    parameter int unsigned c_OBJ_LEN      = 2,
    parameter int unsigned c_BASE_PERIOD  = 20000000,
    parameter logic [31:0] c_LANE_DIV     = 32'h0,
    parameter logic [7:0]  c_LANE_DIR     = 8'h0,
    parameter logic [7:0]  c_LANE_WATER   = 8'h0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_Restart,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Tile_Obj,
    output logic       o_Tile_Water,
    output logic       o_Collided,
    output logic       o_Drowned,
    output logic       o_Carry_Pulse,
    output logic       o_Carry_Dir
);

    localparam int unsigned      c_BW        = $clog2(c_BASE_PERIOD + 1);
    localparam logic [c_BW-1:0]  c_BASE_LAST = c_BW'(c_BASE_PERIOD - 1);
    localparam logic [c_X_W-1:0] c_W         = c_X_W'(c_GAME_WIDTH);

    logic [c_BW-1:0]        r_Base_Cnt;
    logic                   w_Tick;
    logic [c_X_W-1:0]       w_Render_X;
    logic                   w_Render_Col_Ok;
    logic                   w_Frog_X_Ok;
    logic [c_NUM_LANES-1:0] w_Step;
    logic [c_NUM_LANES-1:0] w_Render_Occ;
    logic [c_NUM_LANES-1:0] w_Frog_Occ;
    logic [c_NUM_LANES-1:0] w_Render_Sel;
    logic [c_NUM_LANES-1:0] w_Frog_Sel;
    logic [c_NUM_LANES-1:0] w_Obj_Hit;
    logic [c_NUM_LANES-1:0] w_Water_Sel;
    logic [c_NUM_LANES-1:0] w_Road_Hit;
    logic [c_NUM_LANES-1:0] w_Off_Log;
    logic [c_NUM_LANES-1:0] w_Carry;
    logic [c_NUM_LANES-1:0] w_Edge;
    logic [c_NUM_LANES-1:0] w_Carry_Right;
    tile_t                  w_Tile_Kind;
    logic                   w_Collided_Nxt;
    logic                   w_Drowned_Nxt;
    logic                   w_Carry_Nxt;
    logic                   w_Dir_Nxt;
    logic                   r_Collided;
    logic                   r_Drowned;
    logic                   r_Carry_Pulse;
    logic                   r_Carry_Dir;

    assign w_Tick = i_Enable && (r_Base_Cnt == c_BASE_LAST);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            r_Base_Cnt <= '0;
        else if (i_Restart)
            r_Base_Cnt <= '0;
        else if (i_Enable)
            r_Base_Cnt <= w_Tick ? '0 : r_Base_Cnt + 1'b1;
    end

    assign w_Render_X      = {1'b0, i_Col_Count_Div};
    assign w_Render_Col_Ok = (w_Render_X < c_W);
    assign w_Frog_X_Ok     = (i_Frogger_X < c_W);

    // At most one lane matches a given row, so the per-lane terms are OR-reduced.
    for (genvar g = 0; g < c_NUM_LANES; g++) begin : gen_lane
        localparam logic       c_WATER = c_LANE_WATER[g];
        localparam logic       c_DIR   = c_LANE_DIR[g];
        localparam logic [6:0] c_ROW   = 7'(c_FIRST_ROW + g);

        lane_mover #(
            .c_GAME_WIDTH  (c_GAME_WIDTH),
            .c_OBJ_PER_LANE(c_OBJ_PER_LANE),
            .c_OBJ_LEN     (c_OBJ_LEN),
            .c_DIV         (c_LANE_DIV[4*g +: 4]),
            .c_DIR         (c_DIR)
        ) u_lane (
            .i_Clk       (i_Clk),
            .i_Rst       (i_Rst),
            .i_Restart   (i_Restart),
            .i_Tick      (w_Tick),
            .i_Render_X  (w_Render_X),
            .i_Frog_X    (i_Frogger_X),
            .o_Step      (w_Step[g]),
            .o_Render_Occ(w_Render_Occ[g]),
            .o_Frog_Occ  (w_Frog_Occ[g])
        );

        assign w_Render_Sel[g]  = ({2'b00, i_Row_Count_Div} == c_ROW) && w_Render_Col_Ok;
        assign w_Frog_Sel[g]    = ({1'b0, i_Frogger_Y} == c_ROW) && w_Frog_X_Ok;
        assign w_Obj_Hit[g]     = w_Render_Sel[g] && w_Render_Occ[g];
        assign w_Water_Sel[g]   = w_Render_Sel[g] && c_WATER;
        assign w_Road_Hit[g]    = w_Frog_Sel[g] && !c_WATER && w_Frog_Occ[g];
        assign w_Off_Log[g]     = w_Frog_Sel[g] && c_WATER && !w_Frog_Occ[g];
        assign w_Carry[g]       = w_Frog_Sel[g] && c_WATER && w_Frog_Occ[g] && w_Step[g];
        assign w_Edge[g]        = w_Carry[g] &&
                                  (c_DIR ? (i_Frogger_X == c_W - 1'b1) : (i_Frogger_X == '0));
        assign w_Carry_Right[g] = w_Carry[g] && !w_Edge[g] && c_DIR;
    end

    always_comb begin
        w_Tile_Kind = TILE_WALL;
        if (|w_Render_Sel)
            w_Tile_Kind = (|w_Water_Sel) ? TILE_WATER : TILE_ROAD;
    end

    assign o_Tile_Obj   = |w_Obj_Hit;
    assign o_Tile_Water = (w_Tile_Kind == TILE_WATER);

    always_comb begin
        w_Collided_Nxt = |w_Road_Hit;
        w_Drowned_Nxt  = (|w_Off_Log) || (|w_Edge);
        w_Carry_Nxt    = |(w_Carry & ~w_Edge);
        w_Dir_Nxt      = |w_Carry_Right;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Collided    <= 1'b0;
            r_Drowned     <= 1'b0;
            r_Carry_Pulse <= 1'b0;
            r_Carry_Dir   <= 1'b0;
        end else if (i_Restart) begin
            r_Collided    <= 1'b0;
            r_Drowned     <= 1'b0;
            r_Carry_Pulse <= 1'b0;
            r_Carry_Dir   <= 1'b0;
        end else begin
            r_Collided    <= w_Collided_Nxt;
            r_Drowned     <= w_Drowned_Nxt;
            r_Carry_Pulse <= w_Carry_Nxt;
            r_Carry_Dir   <= w_Dir_Nxt;
        end
    end

    assign o_Collided    = r_Collided;
    assign o_Drowned     = r_Drowned;
    assign o_Carry_Pulse = r_Carry_Pulse;
    assign o_Carry_Dir   = r_Carry_Dir;

endmodule

// File: tb/tb_lane_hazard_ctrl.sv
// Scoreboard bench for lane_hazard_ctrl: a tick-count model of lane motion
// predicts tile lookups and frog events; a negedge monitor compares them.
module tb_lane_hazard_ctrl;

    localparam int P   = 4;
    localparam int N   = 4;
    localparam int FR  = 7;
    localparam int W   = 14;
    localparam int OBJ = 2;
    localparam int LEN = 2;
    localparam int S   = W / OBJ;

    int div_n[N] = '{1, 0, 2, 1};
    bit dir_n[N] = '{1, 0, 1, 0};
    bit wat_n[N] = '{0, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rs  = 1'b0;
    logic [4:0] col = '0;
    logic [4:0] row = '0;
    logic [5:0] fx  = '0;
    logic [5:0] fy  = '0;
    logic       o_Tile_Obj, o_Tile_Water, o_Collided, o_Drowned, o_Carry_Pulse, o_Carry_Dir;

    int checks   = 0;
    int failures = 0;
    int m_b      = 0;   // enabled cycles since restart, mod P
    int m_T      = 0;   // base ticks since restart

    typedef struct packed {bit col; bit drn; bit pls; bit dir;} reg_exp_t;
    typedef struct packed {bit obj; bit wat;} comb_exp_t;
    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];

    lane_hazard_ctrl #(
        .c_NUM_LANES   (N),
        .c_FIRST_ROW   (FR),
        .c_GAME_WIDTH  (W),
        .c_OBJ_PER_LANE(OBJ),
        .c_OBJ_LEN     (LEN),
        .c_BASE_PERIOD (P),
        .c_LANE_DIV    (32'h0000_1201),
        .c_LANE_DIR    (8'h05),
        .c_LANE_WATER  (8'h0C)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Enable       (en),
        .i_Restart      (rs),
        .i_Col_Count_Div(col),
        .i_Row_Count_Div(row),
        .i_Frogger_X    (fx),
        .i_Frogger_Y    (fy),
        .o_Tile_Obj     (o_Tile_Obj),
        .o_Tile_Water   (o_Tile_Water),
        .o_Collided     (o_Collided),
        .o_Drowned      (o_Drowned),
        .o_Carry_Pulse  (o_Carry_Pulse),
        .o_Carry_Dir    (o_Carry_Dir)
    );

    always #5 clk = ~clk;

    function automatic int lane_off(input int n);
        int steps;
        steps = (m_T / (div_n[n] + 1)) % W;
        return dir_n[n] ? steps : (W - steps) % W;
    endfunction

    function automatic bit occ(input int x, input int off);
        int rel;
        rel = ((x - off) % W + W) % W;
        return (rel < OBJ * S) && ((rel % S) < LEN);
    endfunction

    function automatic comb_exp_t comb_expect();
        comb_exp_t c;
        int r, x;
        c = '0;
        r = int'(row);
        x = int'(col);
        if (r >= FR && r < FR + N && x < W) begin
            c.obj = occ(x, lane_off(r - FR));
            c.wat = wat_n[r - FR];
        end
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge rst) begin
        m_b = 0;
        m_T = 0;
    end

    // Reference: decide frog events from the pre-edge lane positions, then advance time.
    always @(posedge clk) begin
        reg_exp_t e;
        bit tick, st, oc;
        int n, x, y;
        e = '0;
        if (rst || rs) begin
            m_b = 0;
            m_T = 0;
        end else begin
            tick = en && (m_b == P - 1);
            x = int'(fx);
            y = int'(fy);
            if (y >= FR && y < FR + N && x < W) begin
                n  = y - FR;
                oc = occ(x, lane_off(n));
                st = tick && ((m_T % (div_n[n] + 1)) == div_n[n]);
                if (!wat_n[n])
                    e.col = oc;
                else if (!oc)
                    e.drn = 1'b1;
                else if (st) begin
                    if ((dir_n[n] && x == W - 1) || (!dir_n[n] && x == 0))
                        e.drn = 1'b1;
                    else begin
                        e.pls = 1'b1;
                        e.dir = dir_n[n];
                    end
                end
            end
            if (en) begin
                if (tick) m_T++;
                m_b = (m_b + 1) % P;
            end
        end
        reg_q.push_back(e);
    end

    always @(negedge clk) begin
        comb_exp_t c;
        reg_exp_t  e;
        if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            chk("tile_obj", o_Tile_Obj, c.obj);
            chk("tile_water", o_Tile_Water, c.wat);
        end
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            chk("collided", o_Collided, e.col);
            chk("drowned", o_Drowned, e.drn);
            chk("carry_pulse", o_Carry_Pulse, e.pls);
            if (e.pls) chk("carry_dir", o_Carry_Dir, e.dir);
        end
    end

    task automatic drive(input bit e, input bit r, input int c, input int rw, input int x, input int y);
        @(posedge clk);
        #1;
        en  = e;
        rs  = r;
        col = c[4:0];
        row = rw[4:0];
        fx  = x[5:0];
        fy  = y[5:0];
        comb_q.push_back(comb_expect());
    endtask

    task automatic rand_cycle(input bit allow_rs);
        drive(($urandom % 10) != 0, allow_rs && (($urandom % 100) == 0),
              int'($urandom % 16), 5 + int'($urandom % 8),
              int'($urandom % 16), 5 + int'($urandom % 8));
    endtask

    task automatic restart_pulse();
        drive(1'b0, 1'b1, 0, FR, 0, 0);
    endtask

    // Called right after a drive: asserts reset between clock edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_collided", o_Collided, 0);
        chk("rst_drowned", o_Drowned, 0);
        chk("rst_carry_pulse", o_Carry_Pulse, 0);
        chk("rst_carry_dir", o_Carry_Dir, 0);
        reg_q.delete();
        comb_q.delete();
        comb_q.push_back(comb_expect());
        drive(1'b1, 1'b0, 0, FR, 1, FR);
        drive(1'b1, 1'b0, 13, FR + 1, 2, FR);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) drive(1'b0, 1'b0, 0, FR, 0, 0);
        rst = 1'b0;

        // Tick rate / lane 0 motion
        restart_pulse();
        for (int i = 0; i < 24; i++) drive(1'b1, 1'b0, i % W, FR, 0, 0);

        // Road hits at offset 0
        restart_pulse();
        drive(1'b0, 1'b0, 0, FR, 1, FR);
        drive(1'b0, 1'b0, 1, FR, 2, FR);
        drive(1'b0, 1'b0, 7, FR, 7, FR);
        drive(1'b0, 1'b0, 2, FR, 8, FR);

        // Left lane wrap seen through the renderer
        restart_pulse();
        for (int i = 0; i < 42; i++) drive(1'b1, 1'b0, i % W, FR + 1, 0, 0);

        // Frog parked in water lanes: carries and edge drowning
        for (int k = 0; k < 4; k++) begin
            int px, py;
            px = (k == 0) ? 3 : (k == 1) ? 13 : (k == 2) ? 0 : 5;
            py = (k < 2) ? FR + 2 : FR + 3;
            restart_pulse();
            for (int i = 0; i < 160; i++)
                drive(1'b1, 1'b0, int'($urandom % 16), FR + 2 + int'($urandom % 2), px, py);
        end

        // Freeze
        for (int i = 0; i < 100; i++)
            drive(1'b0, 1'b0, int'($urandom % 16), 5 + int'($urandom % 8),
                  int'($urandom % 16), 5 + int'($urandom % 8));

        // Restart coinciding with a lane 0 step
        restart_pulse();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 0, FR, 1, FR);
        drive(1'b1, 1'b1, 0, FR, 0, FR);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 13, FR, 13, FR);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 1200; i++) rand_cycle(1'b1);
        async_reset();
        for (int i = 0; i < 1200; i++) rand_cycle(1'b1);

        repeat (2) drive(1'b0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
